// File: rtl/ar_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : ar_mem_port
// Purpose  : Address register (AR) and single-word memory access sequencer.
//            AR loads from the TR address output or the shared bus and can
//            increment. Reads and writes use a req/ack handshake with an
//            abort timeout. Read data is captured in DR. AR or DR can be
//            driven onto out_bus through a register.
// Options  : AR_AUTOINC_EN - when defined, every acked transaction
//            post-increments AR on the ack edge.
// Revision : 1.0 - initial release
// ============================================================================
module ar_mem_port #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] ar_pc_tr,
   input  logic              ld_tr,
   input  logic [DATA_W-1:0] in_bus,
   input  logic              Write,
   input  logic              inc,
   input  logic              rd_start,
   input  logic              wr_start,
   input  logic              Read,
   input  logic              rd_dr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] out_bus,
   output logic              busy,
   output logic              rdata_valid,
   output logic              timeout_err
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

   localparam logic [7:0] C_TMO = 8'(TIMEOUT);

`ifdef AR_AUTOINC_EN
   localparam logic C_AUTOINC = 1'b1;
`else
   localparam logic C_AUTOINC = 1'b0;
`endif

   state_t            state_q;
   logic [ADDR_W-1:0] ar_q;
   logic [DATA_W-1:0] dr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] out_bus_q;
   logic [DATA_W-1:0] out_bus_d;
   logic              req_q;
   logic              we_q;
   logic              busy_q;
   logic              rvalid_q;
   logic              tmo_err_q;
   logic [7:0]        cnt_q;
   logic [7:0]        cnt_d;
   logic [ADDR_W-1:0] ar_inc_d;

   assign cnt_d    = cnt_q + 8'd1;
   assign ar_inc_d = ar_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Transaction sequencer; also owns AR so that AR stays frozen while busy
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         ar_q      <= '0;
         dr_q      <= '0;
         wdata_q   <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         busy_q    <= 1'b0;
         rvalid_q  <= 1'b0;
         tmo_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (wr_start || rd_start) begin
                  // A start wins over any same-cycle AR update; write beats read
                  state_q   <= S_REQ;
                  req_q     <= 1'b1;
                  busy_q    <= 1'b1;
                  we_q      <= wr_start;
                  tmo_err_q <= 1'b0;
                  cnt_q     <= '0;
                  if (wr_start) begin
                     wdata_q <= in_bus;
                  end
               end else if (Write) begin
                  ar_q <= in_bus[ADDR_W-1:0];
               end else if (ld_tr) begin
                  ar_q <= ar_pc_tr;
               end else if (inc) begin
                  ar_q <= ar_inc_d;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  we_q    <= 1'b0;
                  if (!we_q) begin
                     dr_q     <= mem_rdata;
                     rvalid_q <= 1'b1;
                  end
                  if (C_AUTOINC) begin
                     ar_q <= ar_inc_d;
                  end
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == C_TMO) begin
                     state_q   <= S_IDLE;
                     req_q     <= 1'b0;
                     busy_q    <= 1'b0;
                     we_q      <= 1'b0;
                     tmo_err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   // Bus source select: DR has priority over AR, otherwise drive zero
   always_comb begin
      out_bus_d = '0;
      if (rd_dr) begin
         out_bus_d = dr_q;
      end else if (Read) begin
         out_bus_d = {{(DATA_W-ADDR_W){1'b0}}, ar_q};
      end
   end

   // Registered bus drive, one cycle behind the select strobes
   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_bus_q <= '0;
      end else begin
         out_bus_q <= out_bus_d;
      end
   end

   assign mem_addr    = ar_q;
   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_wdata   = wdata_q;
   assign out_bus     = out_bus_q;
   assign busy        = busy_q;
   assign rdata_valid = rvalid_q;
   assign timeout_err = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ar_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_ar_mem_port
// Purpose  : Self-checking bench for ar_mem_port with a transaction-level
//            reference model (AR / DR / error flag tracked as plain values).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ar_mem_port;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  ar_pc_tr;
   logic        ld_tr;
   logic [15:0] in_bus;
   logic        Write;
   logic        inc;
   logic        rd_start;
   logic        wr_start;
   logic        Read;
   logic        rd_dr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [7:0]  mem_addr;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] out_bus;
   logic        busy;
   logic        rdata_valid;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;

   logic [7:0]  ar_m;
   logic [15:0] dr_m;

   ar_mem_port #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
      .clk(clk), .rstn(rstn), .ar_pc_tr(ar_pc_tr), .ld_tr(ld_tr),
      .in_bus(in_bus), .Write(Write), .inc(inc), .rd_start(rd_start),
      .wr_start(wr_start), .Read(Read), .rd_dr(rd_dr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .out_bus(out_bus),
      .busy(busy), .rdata_valid(rdata_valid), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      ld_tr = 0; Write = 0; inc = 0; rd_start = 0; wr_start = 0;
      Read = 0; rd_dr = 0; mem_ack = 0;
   endtask

   task automatic test_reset();
      rstn = 0; clear_ctl(); ar_pc_tr = 8'hC3; in_bus = 16'h5A5A; mem_rdata = 16'hFFFF;
      step(); step();
      checks++; if ({mem_req, mem_we, busy, rdata_valid, timeout_err} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 00000",
                             {mem_req, mem_we, busy, rdata_valid, timeout_err}); end
      checks++; if (mem_addr !== 8'h00) begin
         errors++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
      checks++; if (out_bus !== 16'h0000 || mem_wdata !== 16'h0000) begin
         errors++; $display("FAIL reset_data: got out_bus=%h wdata=%h expected 0", out_bus, mem_wdata); end
      rstn = 1;
      ar_m = 8'h00; dr_m = 16'h0000;
      // DR must come back as zero after reset
      rd_dr = 1; step(); rd_dr = 0;
      checks++; if (out_bus !== 16'h0000) begin
         errors++; $display("FAIL reset_dr: got %h expected 0000", out_bus); end
   endtask

   task automatic test_load_read();
      ld_tr = 1; ar_pc_tr = 8'h3C; step(); ld_tr = 0; ar_m = 8'h3C;
      checks++; if (mem_addr !== 8'h3C) begin
         errors++; $display("FAIL ld_tr: got %h expected 3c", mem_addr); end
      Read = 1; step(); Read = 0;
      checks++; if (out_bus !== 16'h003C) begin
         errors++; $display("FAIL read_ar: got %h expected 003c", out_bus); end
      step();
      checks++; if (out_bus !== 16'h0000) begin
         errors++; $display("FAIL bus_idle: got %h expected 0000", out_bus); end
      ld_tr = 1; ar_pc_tr = 8'hFF; step(); ld_tr = 0;
      inc = 1; step(); inc = 0; ar_m = 8'h00;
      checks++; if (mem_addr !== 8'h00) begin
         errors++; $display("FAIL inc_wrap: got %h expected 00", mem_addr); end
   endtask

   task automatic test_priority();
      Write = 1; ld_tr = 1; inc = 1; in_bus = 16'h1234; ar_pc_tr = 8'h56;
      step(); clear_ctl(); ar_m = 8'h34;
      checks++; if (mem_addr !== 8'h34) begin
         errors++; $display("FAIL write_prio: got %h expected 34", mem_addr); end
      ld_tr = 1; inc = 1; ar_pc_tr = 8'h77; step(); clear_ctl(); ar_m = 8'h77;
      checks++; if (mem_addr !== 8'h77) begin
         errors++; $display("FAIL ld_over_inc: got %h expected 77", mem_addr); end
      rd_dr = 1; Read = 1; step(); clear_ctl();
      checks++; if (out_bus !== dr_m) begin
         errors++; $display("FAIL rd_dr_prio: got %h expected %h", out_bus, dr_m); end
   endtask

   // One memory transaction. ack_after = REQ cycle on which ack is given,
   // 0 means never ack. A random AR update is offered on the start cycle and
   // random AR ops / starts are offered while busy; all must be ignored.
   task automatic run_txn(input bit do_wr, input bit both, input logic [15:0] wdata,
                          input int ack_after, input logic [15:0] rdata);
      logic [7:0] start_ar;
      bit acked;
      bit addr_ok;
      bit vld_seen;
      int n;
      int exp_n;
      start_ar = ar_m;
      acked = (ack_after >= 1) && (ack_after <= TMO);
      exp_n = acked ? ack_after : TMO;
      wr_start = do_wr; rd_start = !do_wr || both; in_bus = wdata;
      ld_tr = 1'($urandom_range(0, 1)); inc = 1'($urandom_range(0, 1));
      Write = 1'($urandom_range(0, 1)); ar_pc_tr = 8'($urandom);
      step(); clear_ctl();
      checks++; if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== do_wr || timeout_err !== 1'b0) begin
         errors++; $display("FAIL txn_start: got req=%b busy=%b we=%b terr=%b expected 1 1 %b 0",
                             mem_req, busy, mem_we, timeout_err, do_wr); end
      checks++; if (mem_addr !== start_ar) begin
         errors++; $display("FAIL txn_addr: got %h expected %h", mem_addr, start_ar); end
      if (do_wr) begin
         checks++; if (mem_wdata !== wdata) begin
            errors++; $display("FAIL txn_wdata: got %h expected %h", mem_wdata, wdata); end
      end
      n = 0; addr_ok = 1; vld_seen = 0;
      while (mem_req === 1'b1 && n < 300) begin
         n++;
         if (mem_addr !== start_ar) addr_ok = 0;
         if (rdata_valid !== 1'b0) vld_seen = 1;
         inc = 1'($urandom_range(0, 1)); Write = 1'($urandom_range(0, 1));
         ld_tr = 1'($urandom_range(0, 1)); rd_start = 1'($urandom_range(0, 1));
         wr_start = 1'($urandom_range(0, 1)); in_bus = 16'($urandom); ar_pc_tr = 8'($urandom);
         mem_ack = (n == ack_after);
         mem_rdata = (n == ack_after) ? rdata : 16'($urandom);
         step(); clear_ctl();
      end
      checks++; if (n !== exp_n) begin
         errors++; $display("FAIL req_cycles: got %0d expected %0d", n, exp_n); end
      checks++; if (!addr_ok || vld_seen) begin
         errors++; $display("FAIL busy_stable: got addr_ok=%b vld_seen=%b expected 1 0", addr_ok, vld_seen); end
      checks++; if (busy !== 1'b0 || rdata_valid !== (acked && !do_wr) || timeout_err !== !acked) begin
         errors++; $display("FAIL txn_end: got busy=%b vld=%b terr=%b expected 0 %b %b",
                             busy, rdata_valid, timeout_err, acked && !do_wr, !acked); end
      if (acked && !do_wr) dr_m = rdata;
`ifdef AR_AUTOINC_EN
      if (acked) ar_m = ar_m + 8'd1;
`endif
      checks++; if (mem_addr !== ar_m) begin
         errors++; $display("FAIL txn_ar: got %h expected %h", mem_addr, ar_m); end
      rd_dr = 1; Read = 1; step(); clear_ctl();
      checks++; if (out_bus !== dr_m || rdata_valid !== 1'b0 || timeout_err !== !acked) begin
         errors++; $display("FAIL txn_dr: got bus=%h vld=%b terr=%b expected %h 0 %b",
                             out_bus, rdata_valid, timeout_err, dr_m, !acked); end
   endtask

   task automatic test_read();
      ld_tr = 1; ar_pc_tr = 8'h10; step(); clear_ctl(); ar_m = 8'h10;
      run_txn(1'b0, 1'b0, 16'h0000, 3, 16'hBEEF);
   endtask

   task automatic test_write_wins();
      run_txn(1'b1, 1'b1, 16'hA5A5, 2, 16'h1111);
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 1'b0, 16'h0000, 0, 16'hDEAD);
      run_txn(1'b0, 1'b0, 16'h0000, 1, 16'h4321);
   endtask

   task automatic test_ack_idle();
      mem_ack = 1; mem_rdata = 16'hCAFE; step(); clear_ctl();
      checks++; if (rdata_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL ack_idle: got vld=%b busy=%b expected 0 0", rdata_valid, busy); end
      rd_dr = 1; step(); clear_ctl();
      checks++; if (out_bus !== dr_m) begin
         errors++; $display("FAIL ack_idle_dr: got %h expected %h", out_bus, dr_m); end
   endtask

   task automatic test_random();
      int ack;
      for (int i = 0; i < 24; i++) begin
         Write = 1'($urandom_range(0, 1)); ld_tr = 1'($urandom_range(0, 1));
         inc = 1'($urandom_range(0, 1)); in_bus = 16'($urandom); ar_pc_tr = 8'($urandom);
         if (Write) ar_m = in_bus[7:0];
         else if (ld_tr) ar_m = ar_pc_tr;
         else if (inc) ar_m = ar_m + 8'd1;
         step(); clear_ctl();
         Read = 1; step(); clear_ctl();
         checks++; if (out_bus !== {8'h00, ar_m}) begin
            errors++; $display("FAIL rand_ar: got %h expected %h", out_bus, {8'h00, ar_m}); end
         ack = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), ack, 16'($urandom));
      end
   endtask

   task automatic test_reset_mid();
      rd_start = 1; step(); clear_ctl();
      step();
      rstn = 0; mem_ack = 1; mem_rdata = 16'hFFFF; Read = 1;
      step(); rstn = 1; clear_ctl();
      ar_m = 8'h00; dr_m = 16'h0000;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || out_bus !== 16'h0000 || rdata_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mid: got req=%b busy=%b bus=%h vld=%b expected 0 0 0000 0",
                             mem_req, busy, out_bus, rdata_valid); end
      rd_dr = 1; step(); clear_ctl();
      checks++; if (rdata_valid !== 1'b0 || out_bus !== 16'h0000 || mem_addr !== 8'h00) begin
         errors++; $display("FAIL reset_mid_after: got vld=%b bus=%h addr=%h expected 0 0000 00",
                             rdata_valid, out_bus, mem_addr); end
   endtask

   initial begin
      rstn = 0; clear_ctl(); ar_pc_tr = 0; in_bus = 0; mem_rdata = 0;
      test_reset();
      test_load_read();
      test_priority();
      test_read();
      test_write_wins();
      test_timeout();
      test_ack_idle();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
